controllore_partita: RTL

//  Control FSM directly upstream of the match datapath. Sequences one match: captures the

---
 rtl/controllore_partita.sv | 125 ++++++++++++
 1 files changed

// File: rtl/controllore_partita.sv
// Match-sequencing FSM in front of the match datapath: loads the manche-count config,
// enables counting, forwards moves and closes the match on result, inconsistency or timeout.
module controllore_partita #(
  parameter int unsigned MIN_MANCHE = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned W_TO       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       INIZIA,
  input  logic [1:0] PRIMO,
  input  logic [1:0] SECONDO,
  input  logic [1:0] MANCHE,
  input  logic [1:0] PARTITA,
  input  logic       FINE_CONTO,
  output logic       INIZIO_SETUP,
  output logic       INIZIO_CONTO,
  output logic [1:0] PRIMO_DP,
  output logic [1:0] SECONDO_DP,
  output logic [1:0] STATO,
  output logic [4:0] NUM_MANCHE,
  output logic [4:0] MANCHE_GIOCATE,
  output logic [1:0] RISULTATO,
  output logic       ERRORE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SETUP = 2'b01,
    S_GIOCO = 2'b10,
    S_FINE  = 2'b11
  } stato_t;

  localparam logic [4:0]      MIN_M  = 5'(MIN_MANCHE);
  localparam logic [W_TO-1:0] TO_LIM = W_TO'(TIMEOUT);
  localparam logic [W_TO-1:0] TO_MAX = '1;

  stato_t          stato;
  logic            conto_q;
  logic [W_TO-1:0] to_cnt;
  logic [W_TO-1:0] to_next;
  logic [4:0]      giocate_inc;
  logic [4:0]      giocate_next;
  logic            manche_valida;
  logic            avvia;
  logic            fine_ok;
  logic            incoerente;
  logic            scaduto;

  assign STATO = stato;

  // NOTE: every signal below is assigned on every pass, so no latch can be inferred.
  always_comb begin
    manche_valida = (stato == S_GIOCO) && conto_q && (MANCHE != 2'b00);
    giocate_inc   = (MANCHE_GIOCATE == 5'd31) ? MANCHE_GIOCATE : MANCHE_GIOCATE + 5'd1;
    giocate_next  = manche_valida ? giocate_inc : MANCHE_GIOCATE;
    to_next       = manche_valida ? '0
                  : ((to_cnt == TO_MAX) ? to_cnt : to_cnt + W_TO'(1));
    avvia         = INIZIA && (stato != S_SETUP);
    fine_ok       = conto_q && FINE_CONTO;
    incoerente    = manche_valida && (giocate_inc == NUM_MANCHE);
    scaduto       = (TIMEOUT != 0) && (to_next == TO_LIM);
  end

  // NOTE: non-blocking assignments only, so every decision uses pre-edge register values;
  // later assignments in the same pass (e.g. clearing *_DP on entering FINE) win.
  always_ff @(posedge clk) begin
    if (rst) begin
      stato          <= S_IDLE;
      conto_q        <= 1'b0;
      to_cnt         <= '0;
      INIZIO_SETUP   <= 1'b0;
      INIZIO_CONTO   <= 1'b0;
      PRIMO_DP       <= 2'b00;
      SECONDO_DP     <= 2'b00;
      NUM_MANCHE     <= 5'd0;
      MANCHE_GIOCATE <= 5'd0;
      RISULTATO      <= 2'b00;
      ERRORE         <= 1'b0;
    end else begin
      // Datapath feedback refers to the counting enable of the previous cycle.
      conto_q <= INIZIO_CONTO;

      if (avvia) begin
        // Start or restart: commit the config and present it to the datapath for one cycle.
        stato          <= S_SETUP;
        INIZIO_SETUP   <= 1'b1;
        INIZIO_CONTO   <= 1'b0;
        PRIMO_DP       <= PRIMO;
        SECONDO_DP     <= SECONDO;
        NUM_MANCHE     <= {1'b0, SECONDO, PRIMO} + MIN_M;
        MANCHE_GIOCATE <= 5'd0;
        RISULTATO      <= 2'b00;
        ERRORE         <= 1'b0;
        to_cnt         <= '0;
      end else begin
        case (stato)
          S_SETUP: begin
            stato        <= S_GIOCO;
            INIZIO_SETUP <= 1'b0;
            INIZIO_CONTO <= 1'b1;
            PRIMO_DP     <= PRIMO;
            SECONDO_DP   <= SECONDO;
          end
          S_GIOCO: begin
            PRIMO_DP       <= PRIMO;
            SECONDO_DP     <= SECONDO;
            MANCHE_GIOCATE <= giocate_next;
            to_cnt         <= to_next;
            if (fine_ok || incoerente || scaduto) begin
              stato        <= S_FINE;
              INIZIO_CONTO <= 1'b0;
              PRIMO_DP     <= 2'b00;
              SECONDO_DP   <= 2'b00;
              RISULTATO    <= fine_ok ? PARTITA : 2'b00;
              ERRORE       <= !fine_ok;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
